// File: rtl/calculadora_sequenciador_if.sv
// Byte-stream and result handshake bundle for calculadora_sequenciador.
//   in_valid/in_ready/in_dado   : command byte stream (host -> sequencer)
//   res_valid/res_ready/res_dado/res_erro : result stream (sequencer -> consumer)
// Modports: master = host/consumer side, slave = sequencer side.
interface calculadora_sequenciador_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_dado;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_dado;
  logic       res_erro;

  modport master (
    output in_valid, in_dado, res_ready,
    input  in_ready, res_valid, res_dado, res_erro
  );

  modport slave (
    input  in_valid, in_dado, res_ready,
    output in_ready, res_valid, res_dado, res_erro
  );
endinterface

// File: rtl/calculadora_sequenciador.sv
// Sequential front-end for the 8-bit combinational calculator.
// Collects a code byte, operand A and operand B from a valid/ready byte stream,
// drives them registered into the calculator, captures calc_saida and returns it
// on a valid/ready result port.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   bus (slave)   : in_valid/in_ready/in_dado, res_valid/res_ready/res_dado/res_erro
//   calc_codigo, calc_a, calc_b : registered calculator inputs
//   calc_saida    : calculator combinational result
//   contador_ops  : completed operations, wraps modulo 256
//   erro_timeout  : one-cycle pulse when a stalled frame is aborted
// Optional feature macro: CALC_SEQ_TIMEOUT_EN (mid-frame idle abort after
// TIMEOUT_CICLOS cycles). Undefined: waits forever, erro_timeout tied to 0.
module calculadora_sequenciador #(
  parameter int unsigned TIMEOUT_CICLOS = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  calculadora_sequenciador_if.slave    bus,
  output logic [2:0]                   calc_codigo,
  output logic [7:0]                   calc_a,
  output logic [7:0]                   calc_b,
  input  logic [7:0]                   calc_saida,
  output logic [7:0]                   contador_ops,
  output logic                         erro_timeout
);

  localparam logic [2:0] ESPERA_COD = 3'd0;
  localparam logic [2:0] ESPERA_A   = 3'd1;
  localparam logic [2:0] ESPERA_B   = 3'd2;
  localparam logic [2:0] EXECUTA    = 3'd3;
  localparam logic [2:0] RESPOSTA   = 3'd4;

  if (TIMEOUT_CICLOS < 1 || TIMEOUT_CICLOS > 65535) begin : g_param_check
    $error("TIMEOUT_CICLOS out of range 1..65535");
  end

  logic [2:0] estado_q, estado_d;
  logic       cod_invalido_q;
  logic       res_valid_q;
  logic [7:0] res_dado_q;
  logic       res_erro_q;
  logic       in_fire;
  logic       res_fire;
  logic       timeout_hit;

  assign bus.in_ready  = (estado_q == ESPERA_COD) || (estado_q == ESPERA_A) ||
                         (estado_q == ESPERA_B);
  assign bus.res_valid = res_valid_q;
  assign bus.res_dado  = res_dado_q;
  assign bus.res_erro  = res_erro_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign res_fire = res_valid_q && bus.res_ready && (estado_q == RESPOSTA);

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimite = 16'(TIMEOUT_CICLOS - 1);

  logic [15:0] ocioso_q;
  logic        erro_timeout_q;
  logic        meio_quadro;

  assign meio_quadro = (estado_q == ESPERA_A) || (estado_q == ESPERA_B);
  // An accepted byte in the limit cycle wins over the abort.
  assign timeout_hit = meio_quadro && !in_fire && (ocioso_q == TimeoutLimite);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocioso_q       <= 16'd0;
      erro_timeout_q <= 1'b0;
    end else begin
      erro_timeout_q <= timeout_hit;
      // Held at zero outside ESPERA_A/ESPERA_B, so entering ESPERA_COD clears it.
      if (in_fire || !meio_quadro || timeout_hit) begin
        ocioso_q <= 16'd0;
      end else begin
        ocioso_q <= ocioso_q + 16'd1;
      end
    end
  end

  assign erro_timeout = erro_timeout_q;
`else
  assign timeout_hit  = 1'b0;
  assign erro_timeout = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA_COD: if (in_fire) estado_d = ESPERA_A;
      ESPERA_A: begin
        if (in_fire)          estado_d = ESPERA_B;
        else if (timeout_hit) estado_d = ESPERA_COD;
      end
      ESPERA_B: begin
        if (in_fire)          estado_d = EXECUTA;
        else if (timeout_hit) estado_d = ESPERA_COD;
      end
      EXECUTA:  estado_d = RESPOSTA;
      RESPOSTA: if (res_fire) estado_d = ESPERA_COD;
      default:  estado_d = ESPERA_COD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= ESPERA_COD;
      calc_codigo    <= 3'd0;
      calc_a         <= 8'd0;
      calc_b         <= 8'd0;
      cod_invalido_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_dado_q     <= 8'd0;
      res_erro_q     <= 1'b0;
      contador_ops   <= 8'd0;
    end else begin
      estado_q <= estado_d;
      if (in_fire && estado_q == ESPERA_COD) begin
        calc_codigo    <= bus.in_dado[2:0];
        cod_invalido_q <= (bus.in_dado > 8'd4);
      end
      if (in_fire && estado_q == ESPERA_A) calc_a <= bus.in_dado;
      if (in_fire && estado_q == ESPERA_B) calc_b <= bus.in_dado;
      if (timeout_hit) calc_codigo <= 3'd0;
      if (estado_q == EXECUTA) begin
        res_dado_q  <= calc_saida;
        res_erro_q  <= cod_invalido_q;
        res_valid_q <= 1'b1;
      end
      if (res_fire) begin
        res_valid_q  <= 1'b0;
        contador_ops <= contador_ops + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_calculadora_sequenciador.sv
// Self-checking bench for calculadora_sequenciador: directed frames from the
// test plan, backpressure, mid-frame reset, randomized frames against a
// behavioural model, and (with CALC_SEQ_TIMEOUT_EN) the idle abort.
module tb_calculadora_sequenciador;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] calc_codigo;
  logic [7:0] calc_a, calc_b, calc_saida, contador_ops;
  logic       erro_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int ops_model = 0;

  calculadora_sequenciador_if bus_if ();

  calculadora_sequenciador #(.TIMEOUT_CICLOS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if.slave),
    .calc_codigo  (calc_codigo),
    .calc_a       (calc_a),
    .calc_b       (calc_b),
    .calc_saida   (calc_saida),
    .contador_ops (contador_ops),
    .erro_timeout (erro_timeout)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational calculator attached to the sequencer.
  always_comb begin
    calc_saida = 8'd0;
    case (calc_codigo)
      3'd1: calc_saida = calc_a;
      3'd2: calc_saida = calc_b;
      3'd3: calc_saida = calc_a + calc_b;
      3'd4: calc_saida = calc_a - calc_b;
      default: calc_saida = 8'd0;
    endcase
  end

  // Expected result of a whole frame: only the low three code bits reach the
  // calculator; arithmetic is modulo 256.
  function automatic int expected_result(int cod, int a, int b);
    int op = cod % 8;
    if (op == 1) return a;
    if (op == 2) return b;
    if (op == 3) return (a + b) % 256;
    if (op == 4) return (a - b + 256) % 256;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_dado  = b;
    while (!bus_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic get_result(input int exp_dado, input int exp_erro, input int stall);
    int n = 0;
    while (!bus_if.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_wait", 32'(bus_if.res_valid), 32'd1);
    chk("res_dado", 32'(bus_if.res_dado), 32'(exp_dado));
    chk("res_erro", 32'(bus_if.res_erro), 32'(exp_erro));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_dado", 32'(bus_if.res_dado), 32'(exp_dado));
    end
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    bus_if.res_ready = 1'b0;
    ops_model = (ops_model + 1) % 256;
    chk("res_valid_drop", 32'(bus_if.res_valid), 32'd0);
    chk("in_ready_back", 32'(bus_if.in_ready), 32'd1);
    chk("contador_ops", 32'(contador_ops), 32'(ops_model));
  endtask

  task automatic frame(input int cod, input int a, input int b, input int stall);
    send_byte(8'(cod));
    send_byte(8'(a));
    send_byte(8'(b));
    get_result(expected_result(cod, a, b), (cod > 4) ? 1 : 0, stall);
    chk("calc_a_kept", 32'(calc_a), 32'(a));
    chk("calc_b_kept", 32'(calc_b), 32'(b));
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
    chk("rst_res_dado", 32'(bus_if.res_dado), 32'd0);
    chk("rst_res_erro", 32'(bus_if.res_erro), 32'd0);
    chk("rst_calc", {21'd0, calc_codigo, calc_a}, 32'd0);
    chk("rst_calc_b", 32'(calc_b), 32'd0);
    chk("rst_contador", 32'(contador_ops), 32'd0);
    chk("rst_erro_timeout", 32'(erro_timeout), 32'd0);
  endtask

  initial begin
    int cod, a, b, pulses, saw_valid;
    bus_if.in_valid  = 1'b0;
    bus_if.in_dado   = 8'd0;
    bus_if.res_ready = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First frame with latency check: EXECUTA after B, result on the next edge.
    send_byte(8'h03);
    send_byte(8'h0F);
    send_byte(8'h01);
    chk("lat_exec_valid", 32'(bus_if.res_valid), 32'd0);
    chk("lat_exec_ready", 32'(bus_if.in_ready), 32'd0);
    @(negedge clk);
    chk("lat_res_valid", 32'(bus_if.res_valid), 32'd1);
    get_result(8'h10, 0, 0);

    frame(8'h04, 8'h05, 8'h07, 0);
    frame(8'h03, 8'hFF, 8'h02, 1);
    frame(8'h07, 8'h12, 8'h34, 0);
    frame(8'h01, 8'hAA, 8'h55, 0);

    // Backpressure: result held, next frame's byte refused for 10 cycles.
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_dado  = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_res_valid", 32'(bus_if.res_valid), 32'd1);
      chk("bp_res_dado", 32'(bus_if.res_dado), 32'h02);
      chk("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
    end
    chk("bp_codigo_held", 32'(calc_codigo), 32'd3);
    bus_if.in_valid = 1'b0;
    get_result(8'h02, 0, 0);
    @(negedge clk);
    chk("bp_single_xfer", 32'(contador_ops), 32'(ops_model));

    // Reset in the middle of a frame.
    send_byte(8'h03);
    send_byte(8'h10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    ops_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8'h02, 8'h00, 8'h77, 0);

    // Randomized frames, including codes with high bits set.
    for (int i = 0; i < 24; i++) begin
      cod = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
      a   = int'($urandom_range(0, 255));
      b   = int'($urandom_range(0, 255));
      frame(cod, a, b, int'($urandom_range(0, 3)));
    end
    chk("erro_timeout_idle", 32'(erro_timeout), 32'd0);

`ifdef CALC_SEQ_TIMEOUT_EN
    // Stall after A for longer than the limit: one abort pulse, no result.
    send_byte(8'h03);
    send_byte(8'h01);
    pulses    = 0;
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (erro_timeout) pulses++;
      if (bus_if.res_valid) saw_valid++;
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_no_result", 32'(saw_valid), 32'd0);
    chk("to_codigo", 32'(calc_codigo), 32'd0);
    chk("to_in_ready", 32'(bus_if.in_ready), 32'd1);
    chk("to_contador", 32'(contador_ops), 32'(ops_model));
    frame(8'h03, 8'h20, 8'h22, 0);
`else
    pulses    = 0;
    saw_valid = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end
endmodule
